// File: rtl/idli_pkg.sv
// Shared core types plus the UART receiver state encoding and helpers.
package idli_pkg;

    typedef logic [3:0]  slice_t;
    typedef logic [15:0] data_t;
    typedef logic [1:0]  ctr_t;

    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_PARITY = 3'd3,
        UART_RX_STOP   = 3'd4
    } uart_rx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic slice_t data_slice(input data_t d, input ctr_t c);
        slice_t s;
        case (c)
            2'd0:    s = d[3:0];
            2'd1:    s = d[7:4];
            2'd2:    s = d[11:8];
            2'd3:    s = d[15:12];
            default: s = 4'h0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/idli_uart_rx_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is taken only when a pop
// happens in the same cycle.
module idli_uart_rx_fifo
    import idli_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_push,
    input  data_t i_push_data,
    input  logic  i_pop,
    output data_t o_head,
    output logic  o_full,
    output logic  o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    data_t       r_mem [DEPTH];
    logic        w_push_ok;
    logic        w_pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        o_empty   = (r_wr_ptr == r_rd_ptr);
        o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop_ok  = i_pop && !o_empty;
        w_push_ok = i_push && (!o_full || w_pop_ok);
        o_head    = r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointer and storage update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/idli_uart_rx.sv
// UART receiver (8N1, LSB first) pairing bytes into 16b words read out as 4b slices.
// Define IDLI_UART_RX_PARITY_EN to require an even-parity bit after the data bits.
module idli_uart_rx
    import idli_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_uart_rx,
    input  logic   i_uart_rd,
    input  ctr_t   i_ctr,
    output slice_t o_uart_data,
    output logic   o_uart_valid,
    output logic   o_uart_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMR_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMR_FULL = TW'(CLKS_PER_BIT - 1);

`ifdef IDLI_UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = UART_RX_PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = UART_RX_STOP;
`endif

    logic [1:0]     r_sync;
    uart_rx_state_t r_state;
    logic [TW-1:0]  r_timer;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic [7:0]     r_low;
    logic           r_half;
    logic           r_armed;
    logic           r_err;
    logic           r_rd_active;

    logic  w_rx;
    logic  w_bit_end;
    logic  w_stop_ok;
    logic  w_par_err;
    logic  w_frame_err;
    logic  w_push;
    logic  w_pop;
    logic  w_accept;
    logic  w_rd_live;
    logic  w_overflow;
    logic  w_full;
    logic  w_empty;
    data_t w_push_data;
    data_t w_head;

`ifdef IDLI_UART_RX_PARITY_EN
    assign w_par_err = (r_state == UART_RX_PARITY) && w_bit_end &&
                       (even_parity(r_shift) != w_rx);
`else
    assign w_par_err = 1'b0;
`endif

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_uart_rx};
        end
    end

    // Frame-end decode, byte pairing and read handshake.
    always_comb begin
        w_rx        = r_sync[1];
        w_bit_end   = (r_timer == TMR_FULL);
        w_stop_ok   = (r_state == UART_RX_STOP) && w_bit_end && w_rx;
        w_frame_err = ((r_state == UART_RX_STOP) && w_bit_end && !w_rx) || w_par_err;
        w_push      = w_stop_ok && r_half;
        w_push_data = {r_shift, r_low};
        w_accept    = (i_ctr == 2'd0) && i_uart_rd && !w_empty;
        w_pop       = r_rd_active && (i_ctr == 2'd3);
        w_overflow  = w_push && w_full && !w_pop;
        if (i_ctr == 2'd0) begin
            w_rd_live = w_accept;
        end else begin
            w_rd_live = r_rd_active;
        end
    end

    // Receive FSM: start qualification at mid-bit, then one sample per bit period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= UART_RX_IDLE;
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_low     <= 8'h00;
            r_half    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            case (r_state)
                UART_RX_IDLE: begin
                    r_timer   <= '0;
                    r_bit_idx <= 3'd0;
                    if (!r_armed) begin
                        r_armed <= w_rx;
                    end else if (!w_rx) begin
                        r_state <= UART_RX_START;
                    end
                end
                UART_RX_START: begin
                    if (r_timer == TMR_HALF) begin
                        r_timer <= '0;
                        r_state <= w_rx ? UART_RX_IDLE : UART_RX_DATA;
                    end else begin
                        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                UART_RX_DATA: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= AFTER_DATA;
                        end
                    end else begin
                        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                UART_RX_PARITY: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (w_par_err) begin
                            r_state <= UART_RX_IDLE;
                            r_half  <= 1'b0;
                            r_armed <= 1'b0;
                        end else begin
                            r_state <= UART_RX_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                UART_RX_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_state <= UART_RX_IDLE;
                        if (w_rx) begin
                            r_low  <= r_half ? r_low : r_shift;
                            r_half <= !r_half;
                        end else begin
                            r_half  <= 1'b0;
                            r_armed <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= UART_RX_IDLE;
                    r_timer <= '0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error: bad frame, bad parity or dropped word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_frame_err || w_overflow) begin
            r_err <= 1'b1;
        end
    end

    // A read is decided once at ctr 0 and lasts until the pop at ctr 3.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_active <= 1'b0;
        end else if (i_ctr == 2'd0) begin
            r_rd_active <= w_accept;
        end else if (i_ctr == 2'd3) begin
            r_rd_active <= 1'b0;
        end
    end

    idli_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Slice mux is combinational so the core sees slice i_ctr in the same cycle.
    always_comb begin
        o_uart_data = 4'h0;
        if (w_rd_live) begin
            o_uart_data = data_slice(w_head, i_ctr);
        end else begin
            o_uart_data = 4'h0;
        end
    end

    assign o_uart_valid = !w_empty;
    assign o_uart_err   = r_err;

endmodule

// File: doc/idli_uart_rx.md
Name: idli_uart_rx

Overview:
- UART receiver (8N1, LSB first) for the core's SRC_UART operand source; the far end of the link the core drives through DST_UART.
- Samples a serial line, assembles bytes into 16b words (low byte first), and buffers the words in a small FIFO.
- Returns each word to the core as four 4b slices over one 4-cycle instruction, indexed by the core's ctr_t.

Parameters:
- CLKS_PER_BIT, 16, i_clk cycles per UART bit; must be an even number >= 4.
- FIFO_DEPTH, 2, number of buffered 16b words; must be a power of 2 and >= 2.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_uart_rx  in  1  serial line, idles high, asynchronous to i_clk
- i_uart_rd  in  1  core requests a UART word this instruction; held for all four ctr cycles
- i_ctr  in  2 (ctr_t)  core slice counter
- o_uart_data  out  4 (slice_t)  slice i_ctr of the head word during an accepted read, else 0
- o_uart_valid  out  1  FIFO not empty
- o_uart_err  out  1  sticky: framing error or overflow seen

Behaviour:
- Reset values (asynchronous on i_rst_n low):
  - o_uart_valid=0, o_uart_err=0, o_uart_data=0.
  - Both synchroniser flops=1; FSM=IDLE; FIFO empty; byte-half flag=low; read-active=0.
- Input synchronisation: i_uart_rx passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Bit timer runs modulo CLKS_PER_BIT.
- FSM states and transitions:
  - IDLE: synchronised line =0 -> START, bit timer=0.
  - START: at timer=CLKS_PER_BIT/2-1, line=0 -> DATA, timer=0, bit index=0; line=1 -> IDLE (glitch rejected, no error).
  - DATA: at timer=CLKS_PER_BIT-1, shift the line into bit[index], LSB first. After index 7 -> STOP.
  - STOP: at timer=CLKS_PER_BIT-1, line=1 -> byte done, go to IDLE. Line=0 -> framing error: set err, discard the byte, clear the half flag, wait in IDLE for line=1 before re-arming.
- Byte pairing:
  - Byte with half flag low -> latch as word[7:0], set flag.
  - Byte with half flag high -> word={byte,low}, push to FIFO, clear flag.
- FIFO overflow: a push while full with no same-cycle pop drops the word and sets err. A push and a pop in the same cycle while full are both accepted.
- Read protocol:
  - A read is accepted when i_ctr=0, i_uart_rd=1 and o_uart_valid=1; this sets read-active.
  - While read-active, o_uart_data = head[i_ctr] (slice 0 = bits 3:0), combinationally.
  - At i_ctr=3 while read-active: pop the head and clear read-active.
  - i_uart_rd asserted at i_ctr=0 with the FIFO empty -> no read for this instruction. The core sees 0 data and must check o_uart_valid itself.
  - A word pushed mid-instruction becomes readable only at the next i_ctr=0.
- Latency: o_uart_valid rises the cycle after the STOP-bit sample of the second byte.
- o_uart_err stays sticky until reset; there is no clear port.

Optional Feature:
- IDLI_UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that expects even parity over the 8 data bits.
  - A mismatch is handled exactly as a framing error: byte discarded, half flag cleared, err set.
- Undefined: pure 8N1 with no PARITY state.

Decomposition:
- idli_pkg gains:
  - uart_rx_state_t enum: UART_RX_IDLE, UART_RX_START, UART_RX_DATA, UART_RX_PARITY, UART_RX_STOP.
  - UART_CLKS_PER_BIT default constant.
- Reuses the existing slice_t, data_t and ctr_t types.
- Sub-module idli_uart_rx_fifo: synchronous data_t FIFO with push/pop/full/empty and simultaneous push+pop support.

Test Plan:
- Send bytes 0x34 then 0x12 at CLKS_PER_BIT=16 -> o_uart_valid=1. A read at ctr 0..3 yields slices 4,3,2,1; valid=0 after ctr 3.
- 0-pulse of 4 cycles on an idle line -> no byte, err=0, FSM back in IDLE.
- Stop bit driven 0 on byte 0xAA -> err=1, no word pushed; then 0x01,0x00 -> word 0x0001 readable.
- FIFO_DEPTH=2: send words 0x1111, 0x2222, 0x3333 with no reads -> err=1; reads return 0x1111, then 0x2222, then valid=0.
- Assert i_uart_rd at ctr=0 with FIFO empty, and a word completes at ctr=2 -> o_uart_data=0 for that instruction; the word is read on the next ctr 0..3.
- Reset asserted mid-DATA of a low byte -> all outputs 0 and FIFO empty; a fresh 0x78,0x56 after reset reads as 0x5678.
- With IDLI_UART_RX_PARITY_EN: 0x03 with parity bit 1 -> err=1, byte dropped.
